// File: rtl/sub_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : sub_seq_if
// Purpose  : Request/result bundle between a requester and sub_seq_ctrl.
//            The requester (master) issues start with operands A, B and Bin.
//            The sequencer (slave) reports busy, a one-cycle done pulse and
//            the registered result Diff, Bout and zero.
// Ports    : start, A[WIDTH], B[WIDTH], Bin   requester -> sequencer
//            busy, done, Diff[WIDTH], Bout, zero  sequencer -> requester
// Revision : 1.0  initial release
// ============================================================================
interface sub_seq_if #(
  parameter int NIBBLES = 4
);
  localparam int C_WIDTH = 4 * NIBBLES;

  logic               start;
  logic [C_WIDTH-1:0] A;
  logic [C_WIDTH-1:0] B;
  logic               Bin;
  logic               busy;
  logic               done;
  logic [C_WIDTH-1:0] Diff;
  logic               Bout;
  logic               zero;

  modport master (
    output start, A, B, Bin,
    input  busy, done, Diff, Bout, zero
  );

  modport slave (
    input  start, A, B, Bin,
    output busy, done, Diff, Bout, zero
  );
endinterface
`default_nettype wire

// File: rtl/sub_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sub_seq_ctrl
// Purpose  : WIDTH-bit unsigned subtract (A - B - Bin) computed one nibble per
//            clock through a single shared 4-bit subtract stage, least
//            significant nibble first, borrow carried between cycles in brw.
// Ports    : clk   clock, rising edge
//            rst   asynchronous active-high reset
//            bus   sub_seq_if slave: start/A/B/Bin in, busy/done/Diff/Bout/
//                  zero out (all outputs come from flops)
// Revision : 1.0  initial release
// ============================================================================
module sub_seq_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic     clk,
  input  logic     rst,
  sub_seq_if.slave bus
);

  localparam int C_WIDTH = 4 * NIBBLES;
  localparam int C_IDXW  = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [C_IDXW-1:0] C_LAST = C_IDXW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [C_WIDTH-1:0] r_a;
  logic [C_WIDTH-1:0] r_b;
  logic               r_brw;
  logic [C_IDXW-1:0]  r_idx;
  logic [C_WIDTH-1:0] r_diff;
  logic               r_bout;
  logic               r_zero;

  logic [3:0]         w_an;
  logic [3:0]         w_bn;
  logic [4:0]         w_sub;
  logic [3:0]         w_dn;
  logic               w_bo;
  logic [C_WIDTH-1:0] w_diff_nxt;
  logic               w_last;
  logic               w_busy;
  logic               w_done;

  assign w_last = (r_idx == C_LAST);

  // Shared 4-bit subtract stage. The nibble select and the nibble write-back
  // are written as loops over constant slices so the muxes stay explicit.
  // A 5-bit difference of two nibbles and a borrow lies in -16..15, so its
  // top bit is exactly the stage borrow-out.
  always_comb begin
    w_an       = '0;
    w_bn       = '0;
    w_diff_nxt = r_diff;
    for (int k = 0; k < NIBBLES; k++) begin
      if (r_idx == C_IDXW'(k)) begin
        w_an = r_a[4*k +: 4];
        w_bn = r_b[4*k +: 4];
      end
    end
    w_sub = {1'b0, w_an} - {1'b0, w_bn} - {4'b0000, r_brw};
    w_dn  = w_sub[3:0];
    w_bo  = w_sub[4];
    for (int k = 0; k < NIBBLES; k++) begin
      if (r_idx == C_IDXW'(k)) begin
        w_diff_nxt[4*k +: 4] = w_dn;
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and status decode
  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_busy = 1'b1;
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_busy      = 1'b1;
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Operand capture and nibble-serial datapath. Diff is left untouched on
  // accept so the previous result stays readable until the first nibble of
  // the new operation lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_brw  <= 1'b0;
      r_idx  <= '0;
      r_diff <= '0;
      r_bout <= 1'b0;
      r_zero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_a   <= bus.A;
            r_b   <= bus.B;
            r_brw <= bus.Bin;
            r_idx <= '0;
          end
        end
        S_RUN: begin
          r_diff <= w_diff_nxt;
          r_brw  <= w_bo;
          if (w_last) begin
            r_bout <= w_bo;
            // zero must see the nibble being written on this same edge
            r_zero <= (w_diff_nxt == '0);
          end else begin
            r_idx <= r_idx + C_IDXW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy = w_busy;
  assign bus.done = w_done;
  assign bus.Diff = r_diff;
  assign bus.Bout = r_bout;
  assign bus.zero = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_sub_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sub_seq_ctrl
// Purpose  : Self-checking bench for sub_seq_ctrl with NIBBLES = 1, 4 and 16.
//            Expected results are queued when an operation is issued and
//            compared when the matching done pulse appears.
// Ports    : none
// Revision : 1.0  initial release
// ============================================================================
module tb_sub_seq_ctrl;

  typedef struct packed {
    logic [63:0] diff;
    logic        bout;
    logic        zero;
  } exp_t;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  exp_t q1[$];
  exp_t q4[$];
  exp_t q16[$];

  sub_seq_if #(.NIBBLES(1))  b1();
  sub_seq_if #(.NIBBLES(4))  b4();
  sub_seq_if #(.NIBBLES(16)) b16();

  sub_seq_ctrl #(.NIBBLES(1))  u1  (.clk(clk), .rst(rst), .bus(b1));
  sub_seq_ctrl #(.NIBBLES(4))  u4  (.clk(clk), .rst(rst), .bus(b4));
  sub_seq_ctrl #(.NIBBLES(16)) u16 (.clk(clk), .rst(rst), .bus(b16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain (WIDTH+1)-bit subtraction
  function automatic exp_t model(input int n, input logic [63:0] a, input logic [63:0] b,
                                 input logic bin);
    logic [64:0] m;
    logic [64:0] full;
    exp_t        e;
    m      = (65'd1 << (4 * n)) - 65'd1;
    full   = ({1'b0, a} & m) - ({1'b0, b} & m) - {64'd0, bin};
    e.diff = full[63:0] & m[63:0];
    e.bout = full[4 * n];
    e.zero = (e.diff == 64'd0);
    return e;
  endfunction

  function automatic logic dn(input int n);
    case (n)
      1:       return b1.done;
      4:       return b4.done;
      default: return b16.done;
    endcase
  endfunction

  function automatic logic bz(input int n);
    case (n)
      1:       return b1.busy;
      4:       return b4.busy;
      default: return b16.busy;
    endcase
  endfunction

  task automatic drive(input int n, input logic s, input logic [63:0] a, input logic [63:0] b,
                       input logic bin);
    case (n)
      1: begin
        b1.start = s; b1.A = a[3:0]; b1.B = b[3:0]; b1.Bin = bin;
      end
      4: begin
        b4.start = s; b4.A = a[15:0]; b4.B = b[15:0]; b4.Bin = bin;
      end
      default: begin
        b16.start = s; b16.A = a; b16.B = b; b16.Bin = bin;
      end
    endcase
  endtask

  // One complete operation on the instance with n nibbles, from idle back to idle
  task automatic op(input int n, input logic [63:0] a, input logic [63:0] b, input logic bin);
    exp_t e;
    int   lat;
    e = model(n, a, b, bin);
    case (n)
      1:       q1.push_back(e);
      4:       q4.push_back(e);
      default: q16.push_back(e);
    endcase
    drive(n, 1'b1, a, b, bin);
    @(posedge clk); #1;
    drive(n, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
    check($sformatf("n%0d_busy_after_accept", n), 64'(bz(n)), 64'd1);
    lat = 0;
    while (!dn(n) && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check($sformatf("n%0d_done_latency", n), 64'(lat), 64'(n));
    check($sformatf("n%0d_busy_in_done", n), 64'(bz(n)), 64'd1);
    @(posedge clk); #1;
    check($sformatf("n%0d_busy_fall", n), 64'(bz(n)), 64'd0);
    check($sformatf("n%0d_single_done", n), 64'(dn(n)), 64'd0);
  endtask

  // Result monitors: every done must have an outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (b4.done) begin
      check("n4_done_has_pending", 64'(q4.size() != 0), 64'd1);
      if (q4.size() != 0) begin
        e = q4.pop_front();
        check("n4_diff", 64'(b4.Diff), e.diff);
        check("n4_bout", 64'(b4.Bout), 64'(e.bout));
        check("n4_zero", 64'(b4.zero), 64'(e.zero));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (b1.done) begin
      check("n1_done_has_pending", 64'(q1.size() != 0), 64'd1);
      if (q1.size() != 0) begin
        e = q1.pop_front();
        check("n1_diff", 64'(b1.Diff), e.diff);
        check("n1_bout", 64'(b1.Bout), 64'(e.bout));
        check("n1_zero", 64'(b1.zero), 64'(e.zero));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (b16.done) begin
      check("n16_done_has_pending", 64'(q16.size() != 0), 64'd1);
      if (q16.size() != 0) begin
        e = q16.pop_front();
        check("n16_diff", b16.Diff, e.diff);
        check("n16_bout", 64'(b16.Bout), 64'(e.bout));
        check("n16_zero", 64'(b16.zero), 64'(e.zero));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
    $fatal(1, "watchdog expired");
  end

  logic [15:0] ta  [0:3] = '{16'h1234, 16'h0001, 16'hFFFF, 16'h8000};
  logic [15:0] tbv [0:3] = '{16'h0234, 16'h0002, 16'hFFFF, 16'h7FFF};

  initial begin
    exp_t e;
    exp_t prev;
    vectors     = 0;
    miscompares = 0;
    rst = 1'b1;
    drive(1, 1'b0, 64'd0, 64'd0, 1'b0);
    drive(4, 1'b0, 64'd0, 64'd0, 1'b0);
    drive(16, 1'b0, 64'd0, 64'd0, 1'b0);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(b4.busy), 64'd0);
    check("rst_done", 64'(b4.done), 64'd0);
    check("rst_diff", 64'(b4.Diff), 64'd0);
    check("rst_bout", 64'(b4.Bout), 64'd0);
    check("rst_zero", 64'(b4.zero), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed operations, default width
    op(4, 64'h0000, 64'h0001, 1'b0);   // 0xFFFF, borrow out
    op(4, 64'h1234, 64'h1234, 1'b0);   // zero result
    op(4, 64'h1000, 64'h0001, 1'b1);   // borrow ripples over three nibbles

    // start pulsed during RUN and during DONE is ignored
    e = model(4, 64'hFFFF, 64'h0000, 1'b0);
    q4.push_back(e);
    drive(4, 1'b1, 64'hFFFF, 64'h0000, 1'b0);
    @(posedge clk); #1;
    drive(4, 1'b1, 64'h1111, 64'h2222, 1'b1);
    repeat (2) begin @(posedge clk); #1; end
    drive(4, 1'b0, 64'h1111, 64'h2222, 1'b1);
    repeat (2) begin @(posedge clk); #1; end
    check("ign_done_on_time", 64'(b4.done), 64'd1);
    drive(4, 1'b1, 64'h0F0F, 64'h0001, 1'b0);
    @(posedge clk); #1;
    drive(4, 1'b0, 64'h0F0F, 64'h0001, 1'b0);
    check("ign_start_in_done_busy", 64'(b4.busy), 64'd0);
    repeat (8) begin @(posedge clk); #1; end
    check("ign_still_idle", 64'(b4.busy), 64'd0);

    // start held high: accepts every NIBBLES+2 edges, results hold until E1
    prev = e;
    b4.start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b4.A   = ta[i];
      b4.B   = tbv[i];
      b4.Bin = 1'(i % 2);
      e = model(4, 64'(ta[i]), 64'(tbv[i]), 1'(i % 2));
      q4.push_back(e);
      @(posedge clk); #1;
      check("thr_busy_after_accept", 64'(b4.busy), 64'd1);
      check("thr_diff_hold_past_accept", 64'(b4.Diff), prev.diff);
      b4.A   = ~ta[i];
      b4.B   = 16'h5A5A;
      b4.Bin = 1'((i + 1) % 2);
      repeat (5) begin @(posedge clk); #1; end
      check("thr_idle_before_reaccept", 64'(b4.busy), 64'd0);
      check("thr_diff_hold_idle", 64'(b4.Diff), e.diff);
      check("thr_bout_hold_idle", 64'(b4.Bout), 64'(e.bout));
      prev = e;
    end
    b4.start = 1'b0;

    // Reset in the second RUN cycle aborts without a done pulse
    drive(4, 1'b1, 64'h4321, 64'h1111, 1'b0);
    @(posedge clk); #1;
    drive(4, 1'b0, 64'h0000, 64'h0000, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort_busy", 64'(b4.busy), 64'd0);
    check("abort_done", 64'(b4.done), 64'd0);
    check("abort_diff", 64'(b4.Diff), 64'd0);
    check("abort_bout", 64'(b4.Bout), 64'd0);
    check("abort_zero", 64'(b4.zero), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
    check("abort_idle", 64'(b4.busy), 64'd0);
    op(4, 64'h00F3, 64'h0001, 1'b0);

    // Narrow and wide instances, boundary cases
    op(1, 64'hF, 64'hB, 1'b0);
    op(1, 64'h0, 64'h0, 1'b1);
    op(16, 64'h0, 64'h0, 1'b1);
    op(16, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    op(16, 64'h8000_0000_0000_0000, 64'h0000_0000_0000_0001, 1'b0);

    // Randomized operations
    for (int i = 0; i < 1000; i++) begin
      op(1, 64'($urandom), 64'($urandom), 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 1000; i++) begin
      op(4, 64'($urandom), 64'($urandom), 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 1000; i++) begin
      op(16, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
    end

    repeat (4) @(posedge clk);
    #1;
    check("q1_drained", 64'(q1.size()), 64'd0);
    check("q4_drained", 64'(q4.size()), 64'd0);
    check("q16_drained", 64'(q16.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sub_seq_ctrl.md
# sub_seq_ctrl

Sequencer that performs a WIDTH-bit unsigned subtraction (A − B − Bin) by time-multiplexing one shared 4-bit subtract stage (fullsub_4bit), one nibble per clock, least-significant nibble first, with the borrow chained between cycles through a register. It sits between a requester issuing start/operand commands and the nibble subtractor datapath. It trades latency for area in wide subtract and compare paths.

## Interface
- NIBBLES, default 4 — number of 4-bit slices; WIDTH = 4*NIBBLES; legal range 1..16.
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  reset, asynchronous, active-high; forces IDLE and clears all registers.
- start  input  1  request; accepted only on a rising edge where state is IDLE.
- A  input  WIDTH  minuend; sampled on the accept edge only.
- B  input  WIDTH  subtrahend; sampled on the accept edge only.
- Bin  input  1  borrow-in; sampled on the accept edge only.
- busy  output  1  high whenever state ≠ IDLE.
- done  output  1  one-cycle pulse: result valid.
- Diff  output  WIDTH  difference, registered.
- Bout  output  1  final borrow-out, registered.
- zero  output  1  high when Diff == 0, registered with Diff.

## Operation
- States: IDLE, RUN, DONE. Nibble index idx is a counter of width ceil(log2(NIBBLES)), minimum 1 bit. Borrow register is brw.
- IDLE: if start=1, latch A, B, Bin into the operand registers and brw. Set idx=0 and go to RUN. Otherwise stay in IDLE.
- RUN: on each edge, drive the shared stage with A[4*idx+:4], B[4*idx+:4] and brw. Write the 4-bit stage result into Diff[4*idx+:4] and the stage borrow-out into brw.
  - If idx = NIBBLES−1: set Bout to the stage borrow-out, set zero to the zero-test of the completed Diff (including the nibble written on this edge), and go to DONE.
  - Otherwise: idx = idx+1.
- DONE: done=1 for exactly this one cycle, then go to IDLE unconditionally.
- Arithmetic: the operation is unsigned modulo 2^WIDTH. {Bout, Diff} equals A − B − Bin evaluated in WIDTH+1 bits. Bout=1 exactly when A < B+Bin.
- Diff, Bout and zero hold their values from done until the edge after the next accepted start. During RUN, Diff is partially updated and is not valid.
- start is ignored in RUN and DONE. Operand inputs are don't-care except on the accept edge.
- Reset asserted at any time, including mid-RUN:
  - state is IDLE, busy=0, done=0;
  - Diff=0, Bout=0, zero=0;
  - idx=0, brw=0, operand registers cleared;
  - the aborted operation produces no done.
- Reset release: first accept is possible on the first rising edge with rst=0.

## Timing
- Call the accept edge E0. Nibble k is processed at edge E(k+1).
- done is high in the cycle following E(NIBBLES). For the default, that is 4 edges after E0.
- busy rises after E0 and falls after E(NIBBLES+1). busy and done are both high during the DONE cycle.
- Throughput: with start held high, accepts occur every NIBBLES+2 edges, at E0, E(NIBBLES+2), and so on.
- All outputs are registered. No combinational path exists from any input to any output.

## Test plan
- Default NIBBLES=4, A=0x0000, B=0x0001, Bin=0 → done exactly 4 edges after accept; Diff=0xFFFF, Bout=1, zero=0. busy is high for 5 cycles.
- A=0x1234, B=0x1234, Bin=0 → Diff=0x0000, Bout=0, zero=1. A=0x1000, B=0x0001, Bin=1 → Diff=0x0FFE, Bout=0; the borrow ripples across 3 nibble boundaries.
- Pulse start again during RUN and during DONE with different operands → ignored. The first result (e.g. 0xFFFF from A=0xFFFF, B=0x0000, Bin=0) is unaffected, and only one done pulse occurs.
- Hold start=1 continuously with alternating operands → accepts every 6 edges. Each Diff/Bout is correct and holds until the edge after the following accept.
- Assert rst during the 2nd RUN cycle → busy, done, Diff, Bout and zero go to 0 immediately, with no done pulse. A new start (A=0x00F3, B=0x0001, Bin=0) then completes normally with Diff=0x00F2.
- NIBBLES=1, A=0xF, B=0xB, Bin=0 → Diff=0x4, Bout=0, done 1 edge after accept. Randomized compare against A−B−Bin over 1000 operations for NIBBLES=1, 4 and 16.
